// File: rtl/vga_pkg.sv
// Shared constants and types for the framebuffer path: RAM geometry,
// 640x480 timing, read-tag ownership and the processor-side FSM states.
package vga_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME_WORDS = H_VISIBLE * V_VISIBLE;

  typedef enum logic {OWN_DISP, OWN_CPU} owner_t;

  typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, HOLD} cpu_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Display, processor and RAM signal bundle; slave is the arbiter side,
// master is the surrounding system (VGA pipeline, CPU bus, RAM).
interface vram_arbiter_if #(
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int DATA_W = vga_pkg::DATA_W
);
  logic              Disp_Req;
  logic [ADDR_W-1:0] Disp_Addr;
  logic              Disp_Data_Valid;
  logic [DATA_W-1:0] Disp_Data;
  logic              Disp_Drop;
  logic              Cpu_Req;
  logic              Cpu_We;
  logic [ADDR_W-1:0] Cpu_Addr;
  logic [DATA_W-1:0] Cpu_Wdata;
  logic              Cpu_Ack;
  logic [DATA_W-1:0] Cpu_Rdata;
  logic              Mem_En;
  logic              Mem_We;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Wdata;
  logic [DATA_W-1:0] Mem_Rdata;

  modport slave (
    input  Disp_Req, Disp_Addr, Cpu_Req, Cpu_We, Cpu_Addr, Cpu_Wdata, Mem_Rdata,
    output Disp_Data_Valid, Disp_Data, Disp_Drop, Cpu_Ack, Cpu_Rdata,
           Mem_En, Mem_We, Mem_Addr, Mem_Wdata
  );

  modport master (
    output Disp_Req, Disp_Addr, Cpu_Req, Cpu_We, Cpu_Addr, Cpu_Wdata, Mem_Rdata,
    input  Disp_Data_Valid, Disp_Data, Disp_Drop, Cpu_Ack, Cpu_Rdata,
           Mem_En, Mem_We, Mem_Addr, Mem_Wdata
  );
endinterface

// File: rtl/vram_tag_pipe.sv
// {valid, owner} shift register tracking reads in flight so each returning
// RAM word can be routed to the requester that issued it.
module vram_tag_pipe
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display reads have priority, the processor
// gets a forced slot after STARVE_LIMIT denied cycles at the cost of one display word.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W       = vga_pkg::ADDR_W,
  parameter int DATA_W       = vga_pkg::DATA_W,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 64
) (
  input logic           Fast_Clock,
  input logic           Reset,
  vram_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  cpu_state_t       state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             cpu_elig, forced, grant_cpu, grant_disp;
  logic             ack_nxt, rdata_ld;
  tag_t             tag_in, tag_out;

  always_comb begin
    cpu_elig     = bus.Cpu_Req && (state == IDLE);
    forced       = cpu_elig && (starve_cnt == LIMIT);
    grant_cpu    = forced || (cpu_elig && !bus.Disp_Req);
    grant_disp   = bus.Disp_Req && !forced;
    tag_in.valid = grant_disp || (grant_cpu && !bus.Cpu_We);
    tag_in.owner = grant_cpu ? OWN_CPU : OWN_DISP;
  end

  vram_tag_pipe #(.DEPTH(RD_LATENCY + 1)) u_tag_pipe (
    .clk     (Fast_Clock),
    .rst     (Reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // HOLD blocks re-acceptance of a request still high during the Ack cycle.
  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    rdata_ld  = 1'b0;
    case (state)
      IDLE:    if (grant_cpu) state_nxt = bus.Cpu_We ? WR_ACK : RD_WAIT;
      WR_ACK:  begin
        ack_nxt   = 1'b1;
        state_nxt = HOLD;
      end
      RD_WAIT: if (tag_out.valid && tag_out.owner == OWN_CPU) begin
        ack_nxt   = 1'b1;
        rdata_ld  = 1'b1;
        state_nxt = HOLD;
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset)                              starve_cnt <= '0;
    else if (grant_cpu)                     starve_cnt <= '0;
    else if (cpu_elig && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      bus.Mem_En          <= 1'b0;
      bus.Mem_We          <= 1'b0;
      bus.Mem_Addr        <= '0;
      bus.Mem_Wdata       <= '0;
      bus.Disp_Drop       <= 1'b0;
      bus.Disp_Data_Valid <= 1'b0;
      bus.Disp_Data       <= '0;
      bus.Cpu_Ack         <= 1'b0;
      bus.Cpu_Rdata       <= '0;
    end else begin
      bus.Mem_En    <= grant_cpu || grant_disp;
      bus.Mem_We    <= grant_cpu && bus.Cpu_We;
      bus.Mem_Addr  <= grant_cpu ? bus.Cpu_Addr : (grant_disp ? bus.Disp_Addr : '0);
      bus.Mem_Wdata <= (grant_cpu && bus.Cpu_We) ? bus.Cpu_Wdata : '0;
      bus.Disp_Drop <= forced && bus.Disp_Req;
      bus.Cpu_Ack   <= ack_nxt;
      bus.Disp_Data_Valid <= tag_out.valid && (tag_out.owner == OWN_DISP);
      if (tag_out.valid && tag_out.owner == OWN_DISP) bus.Disp_Data <= bus.Mem_Rdata;
      if (rdata_ld) bus.Cpu_Rdata <= bus.Mem_Rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1-cycle read-first RAM model.
module tb_vram_arbiter;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(1), .STARVE_LIMIT(64)
  ) dut (
    .Fast_Clock(clk),
    .Reset     (rst),
    .bus       (bus)
  );

  logic [7:0] ram [1024];
  logic [7:0] ram_q = '0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= i[7:0];
    end else if (bus.Mem_En) begin
      if (bus.Mem_We) ram[bus.Mem_Addr[9:0]] <= bus.Mem_Wdata;
      else            ram_q <= ram[bus.Mem_Addr[9:0]];
    end
  end
  assign bus.Mem_Rdata = ram_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_mem_en"},  bus.Mem_En, 0);
    check({pfx, "_mem_we"},  bus.Mem_We, 0);
    check({pfx, "_mem_addr"}, bus.Mem_Addr, 0);
    check({pfx, "_mem_wdata"}, bus.Mem_Wdata, 0);
    check({pfx, "_cpu_ack"}, bus.Cpu_Ack, 0);
    check({pfx, "_cpu_rdata"}, bus.Cpu_Rdata, 0);
    check({pfx, "_disp_valid"}, bus.Disp_Data_Valid, 0);
    check({pfx, "_disp_data"}, bus.Disp_Data, 0);
    check({pfx, "_disp_drop"}, bus.Disp_Drop, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    preload = 1'b1;
    bus.Disp_Req = 0; bus.Disp_Addr = '0;
    bus.Cpu_Req = 0; bus.Cpu_We = 0; bus.Cpu_Addr = '0; bus.Cpu_Wdata = '0;
    step();
    preload = 1'b0;
    step();
    check_all_zero("reset");
    check("reset_starve", 32'(dut.starve_cnt), 0);
    rst = 1'b0;
    step();

    // CPU write alone
    bus.Cpu_Req = 1; bus.Cpu_We = 1; bus.Cpu_Addr = 19'h00010; bus.Cpu_Wdata = 8'hA5;
    step();
    check("wr_mem_en", bus.Mem_En, 1);
    check("wr_mem_we", bus.Mem_We, 1);
    check("wr_mem_addr", bus.Mem_Addr, 32'h10);
    check("wr_mem_wdata", bus.Mem_Wdata, 32'hA5);
    check("wr_ack_early", bus.Cpu_Ack, 0);
    step();
    check("wr_ack", bus.Cpu_Ack, 1);
    check("wr_mem_en_off", bus.Mem_En, 0);
    step();
    check("wr_no_repeat", bus.Mem_En, 0);
    check("wr_ack_single", bus.Cpu_Ack, 0);
    check("wr_ram", ram[16], 32'hA5);
    bus.Cpu_Req = 0;
    step(); step();

    // CPU read
    bus.Cpu_Req = 1; bus.Cpu_We = 0; bus.Cpu_Addr = 19'h00010;
    step();
    check("rd_mem_en", bus.Mem_En, 1);
    check("rd_mem_we", bus.Mem_We, 0);
    check("rd_mem_addr", bus.Mem_Addr, 32'h10);
    step();
    check("rd_ack_early", bus.Cpu_Ack, 0);
    step();
    check("rd_ack", bus.Cpu_Ack, 1);
    check("rd_data", bus.Cpu_Rdata, 32'hA5);
    bus.Cpu_Req = 0;
    step();
    check("rd_ack_single", bus.Cpu_Ack, 0);
    step();

    // Display streaming, addresses 0..7
    for (int k = 0; k < 13; k++) begin
      check($sformatf("stream_valid[%0d]", k), bus.Disp_Data_Valid, (k >= 3 && k <= 10));
      if (k >= 3 && k <= 10) check($sformatf("stream_data[%0d]", k), bus.Disp_Data, k - 3);
      check($sformatf("stream_we[%0d]", k), bus.Mem_We, 0);
      bus.Disp_Req  = (k < 8);
      bus.Disp_Addr = (k < 8) ? 19'(k) : '0;
      step();
    end

    // Starvation: display continuous, CPU write pending at 0x30
    for (int k = 0; k < 80; k++) begin
      check($sformatf("starve_we[%0d]", k), bus.Mem_We, (k == 65));
      check($sformatf("starve_drop[%0d]", k), bus.Disp_Drop, (k == 65));
      check($sformatf("starve_ack[%0d]", k), bus.Cpu_Ack, (k == 66));
      check($sformatf("starve_valid[%0d]", k), bus.Disp_Data_Valid,
            (k >= 3 && k <= 78 && k != 67));
      if (k >= 3 && k <= 78 && k != 67)
        check($sformatf("starve_data[%0d]", k), bus.Disp_Data, 32'h80 + ((k - 3) & 63));
      if (k == 65) begin
        check("starve_wr_addr", bus.Mem_Addr, 32'h30);
        check("starve_wr_data", bus.Mem_Wdata, 32'h5C);
      end
      if (k == 64) check("starve_cnt_sat", 32'(dut.starve_cnt), 64);
      if (k == 67) check("starve_cnt_clr", 32'(dut.starve_cnt), 0);
      bus.Disp_Req  = (k < 76);
      bus.Disp_Addr = 19'(32'h80 + (k & 63));
      bus.Cpu_Req   = (k < 66);
      bus.Cpu_We    = 1; bus.Cpu_Addr = 19'h00030; bus.Cpu_Wdata = 8'h5C;
      step();
    end
    step(); step();

    // Interleave: CPU read then display read on the next cycle
    bus.Cpu_Req = 1; bus.Cpu_We = 0; bus.Cpu_Addr = 19'h00030;
    step();
    check("il_cpu_en", bus.Mem_En, 1);
    check("il_cpu_addr", bus.Mem_Addr, 32'h30);
    bus.Disp_Req = 1; bus.Disp_Addr = 19'h00005;
    step();
    check("il_disp_en", bus.Mem_En, 1);
    check("il_disp_addr", bus.Mem_Addr, 32'h5);
    bus.Disp_Req = 0;
    step();
    check("il_cpu_ack", bus.Cpu_Ack, 1);
    check("il_cpu_data", bus.Cpu_Rdata, 32'h5C);
    check("il_valid_early", bus.Disp_Data_Valid, 0);
    bus.Cpu_Req = 0;
    step();
    check("il_disp_valid", bus.Disp_Data_Valid, 1);
    check("il_disp_data", bus.Disp_Data, 32'h05);
    check("il_ack_single", bus.Cpu_Ack, 0);
    step(); step();

    // Reset during RD_WAIT
    bus.Cpu_Req = 1; bus.Cpu_We = 0; bus.Cpu_Addr = 19'h00010;
    step();
    step();
    rst = 1'b1;
    bus.Cpu_Req = 0;
    #1;
    check_all_zero("rstmid");
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rstmid_no_ack[%0d]", k), bus.Cpu_Ack, 0);
      check($sformatf("rstmid_no_valid[%0d]", k), bus.Disp_Data_Valid, 0);
    end
    bus.Cpu_Req = 1; bus.Cpu_We = 0; bus.Cpu_Addr = 19'h00010;
    step();
    check("post_rst_en", bus.Mem_En, 1);
    step();
    check("post_rst_ack_early", bus.Cpu_Ack, 0);
    step();
    check("post_rst_ack", bus.Cpu_Ack, 1);
    check("post_rst_data", bus.Cpu_Rdata, 32'hA5);
    bus.Cpu_Req = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
